// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: shared widths and stage-register state encoding
package pipe_stage_reg_pkg;

    localparam int XLEN  = 32;
    localparam int OCC_W = 2;

    // State values double as the held-entry count presented on occupancy.
    typedef enum logic [OCC_W-1:0] {
        PIPE_ST_EMPTY = 2'd0,
        PIPE_ST_BUSY  = 2'd1,
        PIPE_ST_FULL  = 2'd2
    } pipe_st_e;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// pipe_stage_slot: payload register with load enable and sync clear; validity lives in the owner
module pipe_stage_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              ld,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] data_q, data_d;

    // Clear wins over load so reset/flush never leave a stale payload.
    always_comb data_d = clr ? '0 : ld ? d : data_q;

    // Payload storage.
    always_ff @(posedge clk) data_q <= data_d;

    assign q = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with flush; define PIPE_STAGE_SKID_EN for a 2-entry skid with registered in_ready
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W         = XLEN*3+8,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occupancy
);

    logic              in_fire, out_fire, main_ld, clr;
    logic [DATA_W-1:0] main_src;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign clr      = reset | (flush & CLEAR_ON_FLUSH);

`ifdef PIPE_STAGE_SKID_EN

    pipe_st_e          state_q, state_d;
    logic              rdy_q, rdy_d, skid_ld, from_skid;
    logic [DATA_W-1:0] skid_data;

    // rdy_q resets high so in_ready rises on the first cycle after release.
    assign in_ready  = !reset & rdy_q;
    assign out_valid = state_q != PIPE_ST_EMPTY;
    assign occupancy = state_q;
    assign main_src  = from_skid ? skid_data : in_data;

    // Next state and slot loads; flush overrides any handshake in the same cycle.
    always_comb begin
        state_d   = state_q;
        main_ld   = 1'b0;
        skid_ld   = 1'b0;
        from_skid = 1'b0;
        case (state_q)
            PIPE_ST_EMPTY: begin
                state_d = in_fire ? PIPE_ST_BUSY : PIPE_ST_EMPTY;
                main_ld = in_fire;
            end
            PIPE_ST_BUSY: begin
                state_d = in_fire ? (out_fire ? PIPE_ST_BUSY : PIPE_ST_FULL)
                                  : (out_fire ? PIPE_ST_EMPTY : PIPE_ST_BUSY);
                main_ld = in_fire & out_fire;
                skid_ld = in_fire & !out_fire;
            end
            PIPE_ST_FULL: begin
                state_d   = out_fire ? PIPE_ST_BUSY : PIPE_ST_FULL;
                main_ld   = out_fire;
                from_skid = 1'b1;
            end
            default: state_d = PIPE_ST_EMPTY;
        endcase
        if (flush) begin
            state_d = PIPE_ST_EMPTY;
            main_ld = 1'b0;
            skid_ld = 1'b0;
        end
        rdy_d = state_d != PIPE_ST_FULL;
    end

    // State and registered ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PIPE_ST_EMPTY;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
        end
    end

    pipe_stage_slot #(.DATA_W(DATA_W)) u_skid (
        .clk (clk),
        .clr (clr),
        .ld  (skid_ld),
        .d   (in_data),
        .q   (skid_data)
    );

`else

    logic valid_q, valid_d;

    assign in_ready  = !reset & (!valid_q | out_ready);
    assign out_valid = valid_q;
    assign occupancy = {1'b0, valid_q};
    assign main_src  = in_data;
    assign main_ld   = in_fire & !flush;

    // A new entry beats a departing one; flush empties the slot.
    always_comb valid_d = flush ? 1'b0 : in_fire ? 1'b1 : out_fire ? 1'b0 : valid_q;

    // Slot validity.
    always_ff @(posedge clk) begin
        if (reset) valid_q <= 1'b0;
        else       valid_q <= valid_d;
    end

`endif

    pipe_stage_slot #(.DATA_W(DATA_W)) u_main (
        .clk (clk),
        .clr (clr),
        .ld  (main_ld),
        .d   (main_src),
        .q   (out_data)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random valid/ready traffic against a queue-based model
module tb_pipe_stage_reg;

    localparam int W = 16;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] q[$];
    logic [W-1:0] src[$];
    logic [W-1:0] hold = '0;

    pipe_stage_reg #(.DATA_W(W), .CLEAR_ON_FLUSH(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic vg, input logic ordy, input logic fl, input logic rst);
        logic         ev, eir, ifire, ofire;
        logic [W-1:0] x;
        x         = '0;
        reset     = rst;
        flush     = fl;
        out_ready = ordy;
        in_valid  = vg && src.size() > 0;
        in_data   = src.size() > 0 ? src[0] : '0;
        @(negedge clk);
        ev = q.size() > 0;
        if (ev) hold = q[0];
        eir = rst ? 1'b0 : (CAP == 2 ? q.size() < 2 : (!ev || ordy));
        chk("out_valid", W'(out_valid), W'(ev));
        chk("out_data", out_data, hold);
        chk("occupancy", W'(occupancy), W'(q.size()));
        chk("in_ready", W'(in_ready), W'(eir));
        ifire = in_valid & eir;
        ofire = ev & ordy;
        @(posedge clk);
        if (ifire) x = src.pop_front();
        if (rst || fl) begin
            q.delete();
            hold = '0;
        end else begin
            if (ofire) void'(q.pop_front());
            if (ifire) q.push_back(x);
        end
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 1; i <= 8; i++) src.push_back(W'(i));
        repeat (10) tick(1'b1, 1'b1, 1'b0, 1'b0);

        src.push_back(W'('hA));
        src.push_back(W'('hB));
        repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) tick(1'b1, 1'b1, 1'b0, 1'b0);

        src.push_back(W'('h1));
        src.push_back(W'('h2));
        repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b0);
        src.push_back(W'('hC));
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        src.delete();
        repeat (2) tick(1'b0, 1'b1, 1'b0, 1'b0);

        src.push_back(W'('h55));
        src.push_back(W'('h66));
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) tick(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) tick(1'b1, 1'b1, 1'b0, 1'b0);

        repeat (10000) begin
            if (src.size() < 4) src.push_back(W'($urandom));
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0, 1'b0);
        end
        src.delete();
        repeat (4) tick(1'b0, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
